response_tree_arb_l2: RTL and testbench



---
 rtl/response_tree_arb_l2_if.sv | 30 +++
 rtl/response_tree_arb_l2.sv | 99 +++++++++
 tb/tb_response_tree_arb_l2.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/response_tree_arb_l2_if.sv
// Response channel bundle between the L2 slave-side response ports and the
// single master-side response port of the arbitrated return tree.
interface response_tree_arb_l2_if #(
  parameter int unsigned N_SLAVE    = 4,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned ID_WIDTH = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  logic [N_SLAVE-1:0]                 data_r_valid_i;
  logic [N_SLAVE-1:0][DATA_WIDTH-1:0] data_r_rdata_i;
  logic [N_SLAVE-1:0]                 data_r_opc_i;
  logic [N_SLAVE-1:0]                 data_r_ready_o;
  logic                               data_r_valid_o;
  logic [DATA_WIDTH-1:0]              data_r_rdata_o;
  logic                               data_r_opc_o;
  logic [ID_WIDTH-1:0]                data_r_id_o;
  logic                               data_r_ready_i;

  // The arbiter tree itself serves the bus
  modport slave (
    input  data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_ready_i,
    output data_r_ready_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_id_o
  );

  // Sources of responses and the consuming master, seen from outside the tree
  modport master (
    output data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_ready_i,
    input  data_r_ready_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_id_o
  );
endinterface

// File: rtl/response_tree_arb_l2.sv
// Registered round-robin response-return tree: N_SLAVE response sources into one
// output slot with valid/ready backpressure, source tagging and contention counting.
module response_tree_arb_l2 #(
  parameter int unsigned N_SLAVE    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  response_tree_arb_l2_if.slave bus,
  input  logic                  clear_i,
  output logic [CNT_WIDTH-1:0]  contention_cnt_o
);

  localparam int unsigned ID_WIDTH = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  opc_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  load_en;
  logic                  any_valid;
  logic [ID_WIDTH-1:0]   winner;
  logic                  multi_valid;
  logic                  contention;
  logic [N_SLAVE-1:0]    ready_c;

  assign load_en     = !valid_q || bus.data_r_ready_i;
  assign multi_valid = $countones(bus.data_r_valid_i) > 1;
  assign contention  = load_en && multi_valid;

  // Round-robin search from rr_ptr, wrapping modulo N_SLAVE
  always_comb begin
    int unsigned         cand_u;
    logic [ID_WIDTH-1:0] cand;
    any_valid = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < N_SLAVE; k++) begin
      cand_u = (32'(rr_ptr_q) + k) % N_SLAVE;
      cand   = ID_WIDTH'(cand_u);
      if (!any_valid && bus.data_r_valid_i[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Accept is one-hot on the winner, and never asserted while in reset
  always_comb begin
    ready_c = '0;
    if (rst_n && load_en && any_valid) begin
      ready_c[winner] = 1'b1;
    end
  end

  assign bus.data_r_ready_o = ready_c;

  // Output slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      opc_q    <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        valid_q  <= 1'b1;
        rdata_q  <= bus.data_r_rdata_i[winner];
        opc_q    <= bus.data_r_opc_i[winner];
        id_q     <= winner;
        rr_ptr_q <= (winner == ID_WIDTH'(N_SLAVE - 1)) ? '0 : winner + 1'b1;
      end else begin
        valid_q  <= 1'b0;
      end
    end
  end

  // Saturating contention counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (contention && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.data_r_valid_o = valid_q;
  assign bus.data_r_rdata_o = rdata_q;
  assign bus.data_r_opc_o   = opc_q;
  assign bus.data_r_id_o    = id_q;
  assign contention_cnt_o   = cnt_q;

endmodule

// File: tb/tb_response_tree_arb_l2.sv
// Scoreboard bench for response_tree_arb_l2 (5 sources, 4-bit counter):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_response_tree_arb_l2;

  localparam int unsigned N   = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned IW  = 3;
  localparam int          MAXC = 15;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          o;
    logic [IW-1:0] id;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          rdy;
  logic [CW-1:0] contention_cnt;

  response_tree_arb_l2_if #(.N_SLAVE(N), .DATA_WIDTH(DW)) bus ();

  response_tree_arb_l2 #(.N_SLAVE(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .clear_i          (clr),
    .contention_cnt_o (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Pending response held by each source until it is accepted
  logic          pend_v [N];
  logic [DW-1:0] pend_d [N];
  logic          pend_o [N];

  // Reference model state
  rsp_t exp_q[$];
  bit   m_full = 1'b0;
  int   m_rr   = 0;
  int   m_cnt  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.data_r_valid_i[i] = pend_v[i];
      bus.data_r_rdata_i[i] = pend_d[i];
      bus.data_r_opc_i[i]   = pend_o[i];
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic r, input logic c);
    rdy = r;
    clr = c;
    bus.data_r_ready_i = r;
    drive();
  endtask

  task automatic add_d(input int i, input logic [DW-1:0] d, input logic o);
    pend_v[i] = 1'b1;
    pend_d[i] = d;
    pend_o[i] = o;
  endtask

  task automatic add(input int i);
    add_d(i, DW'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Model: predict accepts, queue expected responses, track pointer and counter
  always @(negedge clk) begin
    int            w;
    int            c;
    int            pc;
    bit            any;
    bit            load;
    logic [N-1:0]  er;
    rsp_t          e;
    if (rst_n) begin
      any = 1'b0;
      w   = 0;
      pc  = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!any && pend_v[c]) begin
          any = 1'b1;
          w   = c;
        end
        pc += pend_v[k] ? 1 : 0;
      end
      load = !m_full || rdy;
      er   = '0;
      if (load && any) er[w] = 1'b1;
      check("ready_o", 64'(bus.data_r_ready_o), 64'(er));
      check("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
      if (clr) m_cnt = 0;
      else if (load && pc >= 2 && m_cnt < MAXC) m_cnt++;
      if (load) begin
        if (any) begin
          e.d  = pend_d[w];
          e.o  = pend_o[w];
          e.id = IW'(w);
          exp_q.push_back(e);
          pend_v[w] = 1'b0;
          m_rr      = (w + 1) % N;
          m_full    = 1'b1;
        end else begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Monitor: compare each consumed response and the hold behaviour under stall
  bit          stall = 1'b0;
  logic [63:0] prev  = '0;
  always @(negedge clk) begin
    rsp_t        e;
    logic [63:0] cur;
    cur = 64'({bus.data_r_valid_o, bus.data_r_opc_o, bus.data_r_id_o, bus.data_r_rdata_o});
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) check("stall_hold", cur, prev);
      if (bus.data_r_valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_rsp: got id %0d data %0h expected no response at %0t",
                   bus.data_r_id_o, bus.data_r_rdata_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(bus.data_r_id_o), 64'(e.id));
          check("rsp_data", 64'(bus.data_r_rdata_o), 64'(e.d));
          check("rsp_opc", 64'(bus.data_r_opc_o), 64'(e.o));
        end
      end
      stall = bus.data_r_valid_o && !rdy;
      prev  = cur;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
      pend_o[i] = 1'b0;
    end
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    bus.data_r_ready_i = 1'b1;
    bus.data_r_valid_i = '1;
    bus.data_r_rdata_i = '1;
    bus.data_r_opc_i   = '1;
    #3;
    check("reset_ready_o", 64'(bus.data_r_ready_o), 64'd0);
    check("reset_valid_o", 64'(bus.data_r_valid_o), 64'd0);
    check("reset_rdata_o", 64'(bus.data_r_rdata_o), 64'd0);
    check("reset_opc_o", 64'(bus.data_r_opc_o), 64'd0);
    check("reset_id_o", 64'(bus.data_r_id_o), 64'd0);
    check("reset_cnt", 64'(contention_cnt), 64'd0);
    drive();
    wait_edge();
    wait_edge();
    rst_n = 1'b1;

    // Single source on slave 2
    wait_edge(); add_d(2, 32'hDEAD_BEEF, 1'b0); go(1, 0);
    wait_edge(); go(1, 0);

    // Fairness: three sources held together
    wait_edge(); add(0); add(1); add(3); go(1, 0);
    repeat (4) begin wait_edge(); go(1, 0); end

    // Move pointer to 4, then wrap between slaves 4 and 0
    wait_edge(); add(3); go(1, 0);
    wait_edge(); add(4); add(0); go(1, 0);
    repeat (3) begin wait_edge(); go(1, 0); end

    // Backpressure: slot holds slave 1 while slave 2 waits
    wait_edge(); add(1); go(1, 0);
    wait_edge(); add(2); go(0, 0);
    repeat (2) begin wait_edge(); go(0, 0); end
    wait_edge(); go(1, 0);
    repeat (2) begin wait_edge(); go(1, 0); end

    // Counter saturation, then clear during contention
    wait_edge(); go(1, 1);
    repeat (20) begin
      wait_edge();
      for (int i = 0; i < N; i++) if (!pend_v[i]) add(i);
      go(1, 0);
    end
    @(negedge clk);
    check("cnt_saturated", 64'(contention_cnt), 64'(MAXC));
    wait_edge();
    for (int i = 0; i < N; i++) if (!pend_v[i]) add(i);
    go(1, 1);
    wait_edge();
    go(1, 0);
    @(negedge clk);
    check("cnt_cleared", 64'(contention_cnt), 64'd0);

    // Drain, then reset in the middle of a stall
    repeat (8) begin wait_edge(); go(1, 0); end
    wait_edge(); add(3); go(1, 0);
    wait_edge(); add(2); add(4); go(0, 0);
    wait_edge(); go(0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 64'(bus.data_r_valid_o), 64'd0);
    check("midrst_rdata_o", 64'(bus.data_r_rdata_o), 64'd0);
    check("midrst_id_o", 64'(bus.data_r_id_o), 64'd0);
    check("midrst_cnt", 64'(contention_cnt), 64'd0);
    check("midrst_ready_o", 64'(bus.data_r_ready_o), 64'd0);
    m_full = 1'b0;
    m_rr   = 0;
    m_cnt  = 0;
    exp_q.delete();
    wait_edge();
    rst_n = 1'b1;
    go(1, 0);
    repeat (3) begin wait_edge(); go(1, 0); end

    // Randomized traffic with bursts of heavy backpressure
    for (int c = 0; c < 800; c++) begin
      wait_edge();
      for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 1) == 1) add(i);
      go(((c % 100) < 70) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
         $urandom_range(0, 40) == 0);
    end

    repeat (30) begin wait_edge(); go(1, 0); end
    @(negedge clk);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(bus.data_r_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
